// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
//
// Accepts one 512-bit block as 16 big-endian 32-bit words over a
// valid/ready stream. It then emits the schedule words W[0..NUM_WORDS-1],
// one per handshake, to the round engine.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous abort: back to IDLE, window cleared
//   in_valid/in_ready   upstream word handshake; in_word is the message word
//   w_valid/w_ready     downstream schedule word handshake
//   w_data, w_index     schedule word W[t] and its index t
//   w_last              marks t == NUM_WORDS-1
//   busy                high while loading or emitting
//
// Parameter NUM_WORDS (16..64): schedule words emitted per block.
// Optional macro MSGSCHED_BYTESWAP_EN: byte-reverse in_word before storing it
// (little-endian upstream bus).
module sha256_msg_schedule #(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        w_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [4:0]  ld_cnt_q, ld_cnt_d;
  logic [5:0]  em_cnt_q, em_cnt_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] word_in;
  logic [31:0] w_next;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef MSGSCHED_BYTESWAP_EN
  assign word_in = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign word_in = in_word;
`endif

  // With win[k] = W[t+k], the word entering at win[15] is W[t+16].
  generate
    if (NUM_WORDS > 16) begin : g_expand
      assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end else begin : g_passthru
      assign w_next = '0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ld_cnt_d = ld_cnt_q;
    em_cnt_d = em_cnt_q;
    if (flush) begin
      // Overrides any handshake in the same cycle.
      state_d  = S_IDLE;
      win_d    = '{default: '0};
      ld_cnt_d = '0;
      em_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            win_d[0] = word_in;
            ld_cnt_d = 5'd1;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            win_d[ld_cnt_q[3:0]] = word_in;
            if (ld_cnt_q == 5'd15) begin
              ld_cnt_d = '0;
              em_cnt_d = '0;
              state_d  = S_EMIT;
            end else begin
              ld_cnt_d = ld_cnt_q + 5'd1;
            end
          end
        end
        S_EMIT: begin
          if (w_ready) begin
            for (int unsigned i = 0; i < 15; i++) begin
              win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
            if (em_cnt_q == LAST_IDX) begin
              em_cnt_d = '0;
              state_d  = S_IDLE;
            end else begin
              em_cnt_d = em_cnt_q + 6'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Registered ready: it follows the next state, so it drops on the cycle
    // EMIT is entered and returns on the cycle IDLE is re-entered.
    in_ready_d = (state_d != S_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= '{default: '0};
      ld_cnt_q   <= '0;
      em_cnt_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ld_cnt_q   <= ld_cnt_d;
      em_cnt_q   <= em_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign w_valid  = (state_q == S_EMIT);
  assign w_data   = win_q[0];
  assign w_index  = em_cnt_q;
  assign w_last   = (state_q == S_EMIT) && (em_cnt_q == LAST_IDX);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule (default build, NUM_WORDS=64).
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        w_last;
  logic        busy;

  sha256_msg_schedule #(.NUM_WORDS(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_index  (w_index),
    .w_last   (w_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] got_w [64];
  int          got_n;
  logic [31:0] gold  [64];

  typedef struct {
    string             name;
    logic [15:0][31:0] blk;
    int unsigned       idx;
    logic [31:0]       exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook recurrence over a flat 64-entry array.
  task automatic gen_gold(input logic [15:0][31:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) gold[t] = blk[t];
      else gold[t] = ssig1(gold[t-2]) + gold[t-7] + ssig0(gold[t-15]) + gold[t-16];
    end
  endtask

  task automatic cmp_gold(input string nm);
    for (int k = 0; k < 64; k++) chk(nm, got_w[k], gold[k]);
  endtask

  task automatic set_vec(input int i, input string nm, input logic [15:0][31:0] blk,
                         input int unsigned idx, input logic [31:0] exp);
    vecs[i].name = nm;
    vecs[i].blk  = blk;
    vecs[i].idx  = idx;
    vecs[i].exp  = exp;
  endtask

  // Feeds one block and collects the full 64-word stream with throttling.
  task automatic run_block(input logic [15:0][31:0] blk, input int unsigned vpct,
                           input int unsigned rpct);
    int unsigned sent, cyc, last_in_cyc;
    bit          done, stall, seen_valid;
    logic [31:0] held_d;
    logic [5:0]  held_i;
    sent = 0; cyc = 0; last_in_cyc = 0; done = 0; stall = 0; seen_valid = 0;
    held_d = '0; held_i = '0; got_n = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("hold_data", w_data, held_d);
        chk("hold_index", 32'(w_index), 32'(held_i));
      end
      if (w_valid && !seen_valid) begin
        seen_valid = 1;
        chk("first_latency", cyc - last_in_cyc, 32'd1);
      end
      in_valid = (sent < 16) && ($urandom_range(99) < vpct);
      in_word  = blk[sent[3:0]];
      w_ready  = ($urandom_range(99) < rpct);
      if (in_valid && in_ready) begin
        sent++;
        if (sent == 16) last_in_cyc = cyc;
      end
      if (w_valid && w_ready) begin
        if (got_n < 64) got_w[got_n] = w_data;
        chk("w_index", 32'(w_index), 32'(got_n));
        chk("w_last", 32'(w_last), 32'(got_n == 63));
        if (got_n == 63) chk("in_ready_at_last", 32'(in_ready), 32'd0);
        got_n++;
        if (got_n >= 64) done = 1;
      end
      stall  = w_valid && !w_ready;
      held_d = w_data;
      held_i = w_index;
    end
    in_valid = 1'b0;
    chk("block_done", 32'(done), 32'd1);
  endtask

  task automatic post_idle_check();
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_w_valid", 32'(w_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Loads 16 words back to back, then emits with w_ready=1 until index tgt.
  task automatic load_then_emit_to(input logic [15:0][31:0] blk, input int unsigned tgt);
    int cyc;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = blk[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_ready  = 1'b1;
    cyc = 0;
    while (!(w_valid && 32'(w_index) == tgt) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_index", 32'(w_index), tgt);
    chk("data_at_index", w_data, gold[tgt]);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({nm, "_w_data"}, w_data, 32'd0);
    chk({nm, "_w_index"}, 32'(w_index), 32'd0);
    chk({nm, "_w_last"}, 32'(w_last), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0][31:0] abc, zero, w1, w0, w9, rb;

    abc  = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    zero = '0;
    w1   = '0; w1[1] = 32'h00000001;
    w0   = '0; w0[0] = 32'h00000001;
    w9   = '0; w9[9] = 32'h00000005;

    set_vec(0,  "abc_w0",   abc,  0,  32'h61626380);
    set_vec(1,  "abc_w15",  abc,  15, 32'h00000018);
    set_vec(2,  "abc_w16",  abc,  16, 32'h61626380);
    set_vec(3,  "abc_w17",  abc,  17, 32'h000F0000);
    set_vec(4,  "zero_w0",  zero, 0,  32'h00000000);
    set_vec(5,  "zero_w63", zero, 63, 32'h00000000);
    set_vec(6,  "w1_w1",    w1,   1,  32'h00000001);
    set_vec(7,  "w1_w16",   w1,   16, 32'h02004000);
    set_vec(8,  "w0_w16",   w0,   16, 32'h00000001);
    set_vec(9,  "w0_w18",   w0,   18, 32'h0000A000);
    set_vec(10, "w9_w16",   w9,   16, 32'h00000005);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      run_block(vecs[v].blk, 100, 100);
      chk(vecs[v].name, got_w[vecs[v].idx], vecs[v].exp);
      post_idle_check();
    end

    // Full "abc" stream against the model, including W63.
    gen_gold(abc);
    run_block(abc, 100, 100);
    cmp_gold("abc_stream");
    chk("abc_w63", got_w[63], gold[63]);
    post_idle_check();

    // Throttled random blocks.
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < 16; k++) rb[k] = $urandom;
      gen_gold(rb);
      run_block(rb, 70, 60);
      cmp_gold("rand_stream");
      post_idle_check();
    end

    // flush while the 8th input word is presented.
    for (int k = 0; k < 16; k++) rb[k] = $urandom;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = rb[k];
    end
    @(negedge clk);
    in_word = rb[7];
    flush   = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("flush_in_no_valid", 32'(w_valid), 32'd0);
    end
    gen_gold(rb);
    run_block(rb, 100, 100);
    cmp_gold("after_flush_in");
    post_idle_check();

    // flush while W[30] is being accepted.
    for (int k = 0; k < 16; k++) rb[k] = $urandom;
    gen_gold(rb);
    load_then_emit_to(rb, 30);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_w_valid", 32'(w_valid), 32'd0);
    chk("flush_out_w_index", 32'(w_index), 32'd0);
    chk("flush_out_w_data", w_data, 32'd0);
    chk("flush_out_busy", 32'(busy), 32'd0);
    chk("flush_out_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("flush_out_no_valid", 32'(w_valid), 32'd0);
    end
    for (int k = 0; k < 16; k++) rb[k] = $urandom;
    gen_gold(rb);
    run_block(rb, 100, 100);
    cmp_gold("after_flush_out");
    post_idle_check();

    // Asynchronous reset in the middle of EMIT.
    for (int k = 0; k < 16; k++) rb[k] = $urandom;
    gen_gold(rb);
    load_then_emit_to(rb, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) rb[k] = $urandom;
    gen_gold(rb);
    run_block(rb, 100, 100);
    cmp_gold("after_reset");
    post_idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
